// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcodes, FSM encoding and command field widths shared by the ALU command sequencer
package alu_seq_pkg;
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_DIV = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_EQ  = 3'b111;
  localparam int OP_W = 3;
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_HOLD} state_t;
  // Packed command layout is {a, b, op}, MSB first
  function automatic int cmd_w(input int dw);
    return 2 * dw + OP_W;
  endfunction
endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// alu_cmd_sequencer_if: command, ALU and response handshake bundle; master is the sequencer side
interface alu_cmd_sequencer_if #(parameter int DATA_W = 32);
  logic              cmd_valid, cmd_ready;
  logic [DATA_W-1:0] cmd_a, cmd_b;
  logic [2:0]        cmd_op;
  logic [DATA_W-1:0] alu_a, alu_b;
  logic [2:0]        alu_opcode;
  logic              alu_en, alu_ack;
  logic [DATA_W:0]   alu_result;
  logic              rsp_valid, rsp_ready;
  logic [DATA_W:0]   rsp_result;
  logic [2:0]        rsp_op;
  logic              rsp_err;
  modport master (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, alu_ack, alu_result, rsp_ready,
    output cmd_ready, alu_a, alu_b, alu_opcode, alu_en, rsp_valid, rsp_result, rsp_op, rsp_err
  );
  modport slave (
    output cmd_valid, cmd_a, cmd_b, cmd_op, alu_ack, alu_result, rsp_ready,
    input  cmd_ready, alu_a, alu_b, alu_opcode, alu_en, rsp_valid, rsp_result, rsp_op, rsp_err
  );
endinterface

// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo: show-ahead synchronous FIFO, power-of-two depth, pointers wrap naturally
module alu_cmd_fifo #(
  parameter int WIDTH = 67,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign rdata   = mem[rd_ptr];
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= wdata;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count  <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: queues ALU commands, issues one at a time, returns results; ALU_SEQ_DIV_ZERO_CHECK_EN rejects div-by-zero
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int FIFO_DEPTH  = 4,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_cmd_sequencer_if.master  bus,
  output logic                 busy
);
  localparam int CW = cmd_w(DATA_W);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  state_t            state;
  logic [TW-1:0]     timer;
  logic [CW-1:0]     head;
  logic              full, empty, pop;
  logic [AW:0]       count;
  logic [DATA_W-1:0] head_a, head_b;
  logic [2:0]        head_op;
  assign head_a        = head[CW-1 -: DATA_W];
  assign head_b        = head[OP_W +: DATA_W];
  assign head_op       = head[OP_W-1:0];
  assign pop           = (state == ST_IDLE) && !empty;
  assign bus.cmd_ready = !full;
  assign busy          = (count != '0) || (state != ST_IDLE);
  alu_cmd_fifo #(.WIDTH(CW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk, .rst_n,
    .push(bus.cmd_valid), .pop,
    .wdata({bus.cmd_a, bus.cmd_b, bus.cmd_op}),
    .rdata(head), .full, .empty, .count
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state          <= ST_IDLE;
      timer          <= '0;
      bus.alu_a      <= '0;
      bus.alu_b      <= '0;
      bus.alu_opcode <= '0;
      bus.alu_en     <= 1'b0;
      bus.rsp_valid  <= 1'b0;
      bus.rsp_result <= '0;
      bus.rsp_op     <= '0;
      bus.rsp_err    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (!empty) begin
`ifdef ALU_SEQ_DIV_ZERO_CHECK_EN
          if (head_op == OP_DIV && head_b == '0) begin
            bus.rsp_result <= '0;
            bus.rsp_op     <= head_op;
            bus.rsp_err    <= 1'b1;
            bus.rsp_valid  <= 1'b1;
            state          <= ST_HOLD;
          end else
`endif
          begin
            bus.alu_a      <= head_a;
            bus.alu_b      <= head_b;
            bus.alu_opcode <= head_op;
            bus.alu_en     <= 1'b1;
            timer          <= '0;
            state          <= ST_ISSUE;
          end
        end
        ST_ISSUE: if (bus.alu_ack || timer == TW'(ACK_TIMEOUT - 1)) begin
          // Ack wins over a timeout landing on the same edge
          bus.rsp_result <= bus.alu_ack ? bus.alu_result : '0;
          bus.rsp_err    <= !bus.alu_ack;
          bus.rsp_op     <= bus.alu_opcode;
          bus.rsp_valid  <= 1'b1;
          bus.alu_en     <= 1'b0;
          state          <= ST_HOLD;
        end else timer <= timer + TW'(1);
        ST_HOLD: if (bus.rsp_ready) begin
          bus.rsp_valid <= 1'b0;
          state         <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: directed checks of issue timing, backpressure, timeout, hold stability, async reset, div-zero
module tb_alu_cmd_sequencer;
  import alu_seq_pkg::*;
  logic clk = 1'b0;
  logic rst_n;
  logic busy;
  logic ack_on;
  int   n_tests = 0;
  int   n_fail = 0;
  int   en_cycles = 0;
  alu_cmd_sequencer_if #(.DATA_W(32)) bus ();
  alu_cmd_sequencer #(.DATA_W(32), .FIFO_DEPTH(4), .ACK_TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (bus.alu_en === 1'b1) en_cycles++;
  always_comb begin
    case (bus.alu_opcode)
      OP_ADD:  bus.alu_result = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
      OP_SUB:  bus.alu_result = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
      OP_DIV:  bus.alu_result = (bus.alu_b == '0) ? '0 : {1'b0, bus.alu_a / bus.alu_b};
      OP_MUL:  bus.alu_result = {1'b0, bus.alu_a * bus.alu_b};
      OP_AND:  bus.alu_result = {1'b0, bus.alu_a & bus.alu_b};
      OP_OR:   bus.alu_result = {1'b0, bus.alu_a | bus.alu_b};
      OP_XOR:  bus.alu_result = {1'b0, bus.alu_a ^ bus.alu_b};
      default: bus.alu_result = {32'd0, bus.alu_a == bus.alu_b};
    endcase
    bus.alu_ack = bus.alu_en && ack_on;
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    @(negedge clk);
    bus.cmd_a = a;
    bus.cmd_b = b;
    bus.cmd_op = op;
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask
  task automatic wait_rsp(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.rsp_valid !== 1'b1 && n < 60);
    if (bus.rsp_valid !== 1'b1) chk(tag, bus.rsp_valid, 1);
  endtask
  initial begin
    int k, got, stall, bad, seen;
    logic acc, fire;
    rst_n = 1'b0;
    ack_on = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_a = '0;
    bus.cmd_b = '0;
    bus.cmd_op = '0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_alu_en", bus.alu_en, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_result", bus.rsp_result, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    // single add: pop one edge after push, response one edge later
    bus.rsp_ready = 1'b1;
    en_cycles = 0;
    push(32'd5, 32'd3, OP_ADD);
    chk("t1_en_before_pop", bus.alu_en, 0);
    chk("t1_busy", busy, 1);
    @(negedge clk);
    chk("t1_en_issue", bus.alu_en, 1);
    chk("t1_alu_a", bus.alu_a, 5);
    chk("t1_alu_b", bus.alu_b, 3);
    @(negedge clk);
    chk("t1_rsp_valid", bus.rsp_valid, 1);
    chk("t1_rsp_result", bus.rsp_result, 8);
    chk("t1_rsp_err", bus.rsp_err, 0);
    chk("t1_rsp_op", bus.rsp_op, OP_ADD);
    chk("t1_en_after_ack", bus.alu_en, 0);
    @(negedge clk);
    chk("t1_rsp_done", bus.rsp_valid, 0);
    chk("t1_idle", busy, 0);
    chk("t1_en_cycles", en_cycles, 1);
    // backpressure: one in flight plus four queued fills the FIFO
    bus.rsp_ready = 1'b0;
    k = 0;
    got = 0;
    stall = 0;
    bus.cmd_a = 32'd1;
    bus.cmd_b = 32'd10;
    bus.cmd_op = OP_ADD;
    bus.cmd_valid = 1'b1;
    for (int cyc = 0; cyc < 300 && got < 6; cyc++) begin
      acc = bus.cmd_valid && bus.cmd_ready;
      fire = bus.rsp_valid && bus.rsp_ready;
      if (fire) begin
        chk($sformatf("t2_rsp%0d", got), bus.rsp_result, 64'(got + 11));
        got++;
      end
      @(negedge clk);
      if (acc) begin
        k++;
        if (k == 5) chk("t2_full", bus.cmd_ready, 0);
        if (k < 6) bus.cmd_a = 32'(k + 1);
        else bus.cmd_valid = 1'b0;
      end
      if (k >= 5) stall++;
      if (stall == 6) chk("t2_still_full", bus.cmd_ready, 0);
      if (stall == 6) bus.rsp_ready = 1'b1;
    end
    chk("t2_rsp_count", got, 6);
    chk("t2_accepted", k, 6);
    @(negedge clk);
    // ack never arrives: timeout after 15 issue cycles, then the queued command runs
    ack_on = 1'b0;
    bus.rsp_ready = 1'b1;
    en_cycles = 0;
    push(32'd1, 32'd2, OP_ADD);
    push(32'd7, 32'd1, OP_ADD);
    wait_rsp("t3_timeout_wait");
    chk("t3_err", bus.rsp_err, 1);
    chk("t3_result", bus.rsp_result, 0);
    chk("t3_en_cycles", en_cycles, 15);
    ack_on = 1'b1;
    @(negedge clk);
    wait_rsp("t3_next_wait");
    chk("t3_next_result", bus.rsp_result, 8);
    chk("t3_next_err", bus.rsp_err, 0);
    @(negedge clk);
    // eq of all-ones; response must stay frozen while stalled
    bus.rsp_ready = 1'b0;
    en_cycles = 0;
    push(32'hFFFF_FFFF, 32'hFFFF_FFFF, OP_EQ);
    wait_rsp("t4_wait");
    chk("t4_result", bus.rsp_result, 1);
    chk("t4_op", bus.rsp_op, OP_EQ);
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== 33'd1 || bus.rsp_op !== OP_EQ || bus.alu_en !== 1'b0) bad++;
    end
    chk("t4_stable", bad, 0);
    chk("t4_en_cycles", en_cycles, 1);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("t4_released", bus.rsp_valid, 0);
    // async reset mid-issue with three commands queued
    ack_on = 1'b0;
    push(32'd1, 32'd1, OP_ADD);
    push(32'd2, 32'd2, OP_ADD);
    push(32'd3, 32'd3, OP_ADD);
    push(32'd4, 32'd4, OP_ADD);
    chk("t5_issuing", bus.alu_en, 1);
    chk("t5_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_en_async", bus.alu_en, 0);
    chk("t5_rsp_async", bus.rsp_valid, 0);
    chk("t5_busy_async", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ack_on = 1'b1;
    en_cycles = 0;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) seen++;
    end
    chk("t5_no_rsp", seen, 0);
    chk("t5_no_issue", en_cycles, 0);
    // divide by zero
    bus.rsp_ready = 1'b1;
    en_cycles = 0;
    push(32'd9, 32'd0, OP_DIV);
    wait_rsp("t6_wait");
    chk("t6_op", bus.rsp_op, OP_DIV);
`ifdef ALU_SEQ_DIV_ZERO_CHECK_EN
    chk("t6_err", bus.rsp_err, 1);
    chk("t6_result", bus.rsp_result, 0);
    @(negedge clk);
    chk("t6_en_cycles", en_cycles, 0);
`else
    chk("t6_err", bus.rsp_err, 0);
    @(negedge clk);
    chk("t6_en_cycles", en_cycles, 1);
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
